// File: rtl/mem_pkg.sv
// mem_pkg: memory port command/type encodings and the port master state set
package mem_pkg;
  typedef enum logic [1:0] {M_X, M_XRD, M_XWR} fcn_t;
  typedef enum logic [1:0] {MT_B, MT_H, MT_W} typ_t;
  typedef enum logic [2:0] {IDLE, READ, READ_OUT, WRITE, DONE} state_t;
endpackage

// File: rtl/mem_port_master.sv
// mem_port_master: sequences host burst commands into single-word memory requests
module mem_port_master
  import mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int MAXLEN = 16,
  parameter int LW = $clog2(MAXLEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  output logic          done,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [AW-1:0] req_addr,
  output logic [DW-1:0] req_data,
  output fcn_t          req_fcn,
  output typ_t          req_typ,
  input  logic          resp_valid,
  input  logic [DW-1:0] resp_data
);
  state_t state;
  logic [AW-1:0] addr;
  logic [LW-1:0] cnt;
  logic [LW-1:0] len;
  logic wr_req;
  assign len = cmd_len > LW'(MAXLEN) ? LW'(MAXLEN) : cmd_len;
  assign wr_req = state == WRITE && wdata_valid;
  assign cmd_ready = state == IDLE;
  assign done = state == DONE;
  assign req_valid = state == READ || wr_req;
  assign req_fcn = state == READ ? M_XRD : wr_req ? M_XWR : M_X;
  assign req_typ = MT_W;
  assign req_addr = addr;
  assign req_data = wdata;
  assign wdata_ready = state == WRITE && req_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      cnt <= '0;
      rdata_valid <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr <= cmd_addr & ~AW'(SW - 1);
          cnt <= len;
          state <= len == '0 ? DONE : cmd_wr ? WRITE : READ;
        end
        READ: if (req_ready && resp_valid) begin
          rdata <= resp_data;
          rdata_valid <= 1'b1;
          state <= READ_OUT;
        end
        READ_OUT: if (rdata_ready) begin
          rdata_valid <= 1'b0;
          cnt <= cnt - LW'(1);
          addr <= addr + AW'(SW);
          state <= cnt == LW'(1) ? DONE : READ;
        end
        WRITE: if (wdata_valid && req_ready) begin
          cnt <= cnt - LW'(1);
          addr <= addr + AW'(SW);
          state <= cnt == LW'(1) ? DONE : WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: directed vector table plus hand sequences for backpressure, reset and spurious responses
module tb_mem_port_master;
  import mem_pkg::*;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_wr = 0;
  logic [31:0] cmd_addr = 0;
  logic [4:0] cmd_len = 0;
  logic wdata_valid = 0, wdata_ready;
  logic [31:0] wdata = 0;
  logic rdata_valid, rdata_ready = 1;
  logic [31:0] rdata;
  logic done, req_valid, req_ready = 1;
  logic [31:0] req_addr, req_data;
  fcn_t req_fcn;
  typ_t req_typ;
  logic resp_valid, resp_en = 1, spur = 0;
  logic [31:0] resp_data;
  logic [31:0] mem [0:1023];
  logic [31:0] req_q[$], rd_q[$];
  int done_cnt = 0, wbeats = 0, bad = 0, cmps = 0, errs = 0, n;

  mem_port_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
    .wdata(wdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .done(done),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .req_fcn(req_fcn), .req_typ(req_typ), .resp_valid(resp_valid), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  // Same-cycle memory responder; spur injects a response nobody asked for
  assign resp_valid = spur || (req_valid && req_ready && req_fcn == M_XRD && resp_en);
  assign resp_data = spur ? 32'hDEAD_BEEF : mem[req_addr[11:2]];

  always @(posedge clk) begin
    if (req_valid && req_ready && req_fcn == M_XWR) begin
      mem[req_addr[11:2]] <= req_data;
      req_q.push_back(req_addr);
      wbeats <= wbeats + 1;
    end
    if (req_valid && req_ready && resp_valid && req_fcn == M_XRD) req_q.push_back(req_addr);
    if (rdata_valid && rdata_ready) rd_q.push_back(rdata);
    if (done) done_cnt <= done_cnt + 1;
  end

  always @(negedge clk)
    if (!rst && ((req_valid && req_fcn == M_X) || (!req_valid && req_fcn != M_X) ||
        req_typ != MT_W || (req_valid && req_addr[1:0] != 2'b00))) bad <= bad + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_obs;
    req_q.delete();
    rd_q.delete();
    done_cnt = 0;
    wbeats = 0;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] a, input logic [4:0] l,
                         input logic [31:0] wb, input logic [31:0] ws, output int cyc);
    clear_obs();
    cmd_wr = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1;
    wdata_valid = wr; wdata = wb;
    tick();
    cmd_valid = 0;
    cyc = 1;
    while (!done && cyc < 200) begin
      wdata = wb + ws * wbeats;
      tick();
      cyc++;
    end
    wdata_valid = 0;
    tick();
  endtask

  typedef struct {
    logic wr; logic [31:0] addr; logic [4:0] len; logic [31:0] wbase, wstep;
    int beats; logic [31:0] a0, alast, d0, dlast; int cyc;
  } vec_t;
  vec_t tv [6];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 0;
    mem[32'h100 >> 2] = 32'hA; mem[32'h104 >> 2] = 32'hB; mem[32'h108 >> 2] = 32'hC;
    mem[1023] = 32'h77; mem[0] = 32'h88;
    tv[0] = '{1'b0, 32'h100, 5'd3, 32'h0, 32'h0, 3, 32'h100, 32'h108, 32'hA, 32'hC, 7};
    tv[1] = '{1'b1, 32'h202, 5'd2, 32'h11, 32'h11, 2, 32'h200, 32'h204, 32'h11, 32'h22, 3};
    tv[2] = '{1'b0, 32'hFFFF_FFFC, 5'd2, 32'h0, 32'h0, 2, 32'hFFFF_FFFC, 32'h0, 32'h77, 32'h88, 5};
    tv[3] = '{1'b0, 32'h300, 5'd0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1};
    tv[4] = '{1'b1, 32'h400, 5'd20, 32'h5000, 32'h1, 16, 32'h400, 32'h43C, 32'h5000, 32'h500F, 17};
    tv[5] = '{1'b0, 32'h400, 5'd16, 32'h0, 32'h0, 16, 32'h400, 32'h43C, 32'h5000, 32'h500F, 33};
    tick(); tick();
    rst = 0;
    check("reset_outs", {cmd_ready, req_valid, req_fcn, wdata_ready, rdata_valid, done},
          {1'b1, 1'b0, M_X, 1'b0, 1'b0, 1'b0});
    check("reset_rdata", rdata, 32'h0);

    for (int k = 0; k < 6; k++) begin
      run_cmd(tv[k].wr, tv[k].addr, tv[k].len, tv[k].wbase, tv[k].wstep, n);
      check($sformatf("v%0d_cycles", k), n, tv[k].cyc);
      check($sformatf("v%0d_beats", k), req_q.size(), tv[k].beats);
      check($sformatf("v%0d_done", k), done_cnt, 1);
      if (tv[k].beats > 0) begin
        check($sformatf("v%0d_addr0", k), req_q[0], tv[k].a0);
        check($sformatf("v%0d_addrN", k), req_q[req_q.size() - 1], tv[k].alast);
        if (tv[k].wr) begin
          check($sformatf("v%0d_mem0", k), mem[tv[k].a0[11:2]], tv[k].d0);
          check($sformatf("v%0d_memN", k), mem[tv[k].alast[11:2]], tv[k].dlast);
        end else begin
          check($sformatf("v%0d_rd_cnt", k), rd_q.size(), tv[k].beats);
          check($sformatf("v%0d_rd0", k), rd_q[0], tv[k].d0);
          check($sformatf("v%0d_rdN", k), rd_q[rd_q.size() - 1], tv[k].dlast);
        end
      end
    end
    check("no_over_write", mem[32'h440 >> 2], 32'h0);

    // Read backpressure: response retry, then host stall with a stray response
    clear_obs();
    cmd_wr = 0; cmd_addr = 32'h100; cmd_len = 2; cmd_valid = 1; resp_en = 0; rdata_ready = 0;
    tick();
    cmd_valid = 0;
    tick(); tick();
    check("retry_hold", {req_valid, rdata_valid, req_addr}, {1'b1, 1'b0, 32'h100});
    resp_en = 1;
    tick();
    for (int i = 0; i < 5; i++) begin
      spur = (i == 2);
      tick();
      check($sformatf("rd_stall%0d", i), {rdata_valid, req_valid, rdata}, {1'b1, 1'b0, 32'hA});
    end
    spur = 0;
    check("rd_stall_reqs", req_q.size(), 1);
    rdata_ready = 1;
    n = 0;
    while (!done && n < 50) begin tick(); n++; end
    tick();
    check("rd_bp_beats", rd_q.size(), 2);
    check("rd_bp_data1", rd_q[1], 32'hB);
    check("rd_bp_addr1", req_q[1], 32'h104);

    spur = 1;
    tick();
    spur = 0;
    check("idle_spur", {rdata_valid, rdata}, {1'b0, 32'hB});

    // Write backpressure from the memory side
    clear_obs();
    cmd_wr = 1; cmd_addr = 32'h600; cmd_len = 2; cmd_valid = 1; wdata_valid = 1; wdata = 32'h61; req_ready = 0;
    tick();
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_stall%0d", i), {wdata_ready, req_valid, req_fcn}, {1'b0, 1'b1, M_XWR});
      tick();
    end
    check("wr_stall_beats", wbeats, 0);
    req_ready = 1;
    n = 0;
    while (!done && n < 50) begin wdata = wbeats == 0 ? 32'h61 : 32'h62; tick(); n++; end
    wdata_valid = 0;
    tick();
    check("wr_bp_beats", wbeats, 2);
    check("wr_bp_mem0", mem[32'h600 >> 2], 32'h61);
    check("wr_bp_mem1", mem[32'h604 >> 2], 32'h62);

    // Reset after the first of four write beats
    clear_obs();
    cmd_wr = 1; cmd_addr = 32'h700; cmd_len = 4; cmd_valid = 1; wdata_valid = 1; wdata = 32'h71;
    tick();
    cmd_valid = 0;
    tick();
    wdata_valid = 0; rst = 1;
    tick();
    rst = 0; wdata_valid = 1; wdata = 32'h72;
    check("rst_abort", {req_valid, cmd_ready, wdata_ready}, {1'b0, 1'b1, 1'b0});
    tick(); tick(); tick();
    wdata_valid = 0;
    check("rst_beats", wbeats, 1);
    check("rst_no_done", done_cnt, 0);
    check("rst_mem", mem[32'h704 >> 2], 32'h0);
    run_cmd(1'b0, 32'h100, 5'd3, 32'h0, 32'h0, n);
    check("post_rst_cycles", n, 7);
    check("post_rst_rd0", rd_q[0], 32'hA);
    check("post_rst_rd2", rd_q[2], 32'hC);
    check("post_rst_done", done_cnt, 1);

    check("fcn_typ_align", bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
